// File: rtl/mdu_pkg.sv
// mdu_defs: shared encodings and default latencies for the multiply/divide unit
package mdu_defs;
  typedef enum logic [3:0] {
    MDU_NONE  = 4'b0000,
    MDU_MULT  = 4'b0001,
    MDU_MULTU = 4'b0010,
    MDU_DIV   = 4'b0011,
    MDU_DIVU  = 4'b0100,
    MDU_MTHI  = 4'b0101,
    MDU_MTLO  = 4'b0110
  } mdu_op_e;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} mdu_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO registers
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDUIn1,
  input  logic [31:0] MDUIn2,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        IntReq,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d, hi_q, hi_d, lo_q, lo_d;
  logic wr_q, wr_d;
  logic [63:0] prod_s, prod_u, res;
  logic signed [31:0] a_s, b_s, q_s, r_s;
  logic [31:0] q_u, r_u;
  logic is_mul, is_md;
  mdu_op_e op;
  assign op = mdu_op_e'(MDUOp);
  assign is_mul = op == MDU_MULT || op == MDU_MULTU;
  assign is_md = is_mul || op == MDU_DIV || op == MDU_DIVU;
  assign a_s = $signed(MDUIn1);
  assign b_s = $signed(MDUIn2);
  assign prod_s = $signed({{32{MDUIn1[31]}}, MDUIn1}) * $signed({{32{MDUIn2[31]}}, MDUIn2});
  assign prod_u = {32'd0, MDUIn1} * {32'd0, MDUIn2};
  // divisor -1 is special-cased so the INT_MIN / -1 overflow wraps instead of trapping
  assign q_s = b_s == 0 ? 32'sd0 : b_s == -32'sd1 ? -a_s : a_s / b_s;
  assign r_s = (b_s == 0 || b_s == -32'sd1) ? 32'sd0 : a_s % b_s;
  assign q_u = MDUIn2 == 0 ? 32'd0 : MDUIn1 / MDUIn2;
  assign r_u = MDUIn2 == 0 ? 32'd0 : MDUIn1 % MDUIn2;
  assign res = op == MDU_MULT  ? prod_s :
               op == MDU_MULTU ? prod_u :
               op == MDU_DIV   ? {r_s, q_s} : {r_u, q_u};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ph_d = ph_q;
    pl_d = pl_q;
    wr_d = wr_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_RUN) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        hi_d = wr_q ? ph_q : hi_q;
        lo_d = wr_q ? pl_q : lo_q;
      end
    end else if (!IntReq) begin
      if (Start && is_md) begin
        state_d = S_RUN;
        cnt_d = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        {ph_d, pl_d} = res;
        wr_d = is_mul || MDUIn2 != 0;
      end else begin
        hi_d = op == MDU_MTHI ? MDUIn1 : hi_q;
        lo_d = op == MDU_MTLO ? MDUIn1 : lo_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ph_q <= '0;
      pl_q <= '0;
      wr_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      pl_q <= pl_d;
      wr_q <= wr_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign Busy = state_q == S_RUN;
  assign HI = hi_q;
  assign LO = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for the multiply/divide unit
module tb_mdu;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] in1, in2;
  logic [3:0] op;
  logic start, int_req, busy;
  logic [31:0] hi, lo;
  int checks = 0;
  int failures = 0;
  mdu dut (
    .clk(clk), .reset(reset), .MDUIn1(in1), .MDUIn2(in2), .MDUOp(op),
    .Start(start), .IntReq(int_req), .Busy(busy), .HI(hi), .LO(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input bit irq_mid);
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    op = o; in1 = a; in2 = b; start = 1'b1;
    step();
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (i == 0) begin
        chk({tag, "_hi_hold"}, hi, h0);
        chk({tag, "_lo_hold"}, lo, l0);
      end
      int_req = irq_mid && i == 1;
      step();
    end
    int_req = 1'b0;
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask
  initial begin
    reset = 1'b1; in1 = '0; in2 = '0; op = '0; start = 1'b0; int_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
    op = 4'd5; in1 = 32'h12345678;
    step();
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'd14);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = 4'd6; in1 = 32'h9ABCDEF0;
    step();
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    op = 4'd1; in1 = 32'd9; in2 = 32'd9; start = 1'b1; int_req = 1'b1;
    step();
    chk("irq_start_busy", {31'd0, busy}, 32'd0);
    chk("irq_start_hi", hi, 32'h12345678);
    op = 4'd5; start = 1'b0;
    step();
    chk("irq_mthi_hi", hi, 32'h12345678);
    chk("irq_mthi_lo", lo, 32'h9ABCDEF0);
    op = 4'd0; int_req = 1'b0;
    step();
    chk("irq_idle_busy", {31'd0, busy}, 32'd0);
    run_op("div_irq", 4'd3, 32'd100, 32'hFFFFFFF9, 10, 32'd2, 32'hFFFFFFF2, 1'b1);
    op = 4'd3; in1 = 32'd50; in2 = 32'd5; start = 1'b1;
    step();
    start = 1'b0; op = 4'd0;
    step();
    step();
    chk("rst_run_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_run_busy", {31'd0, busy}, 32'd0);
    chk("rst_run_hi", hi, 32'd0);
    chk("rst_run_lo", lo, 32'd0);
    step();
    chk("rst_run_stay", {31'd0, busy}, 32'd0);
    run_op("mult_post", 4'd1, 32'd1000, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFC18, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
